// File: rtl/btn_event_decoder.sv
// Button event decoder: turns a debounced button level into short-press,
// double-click and long-press pulses, plus a held flag for long presses.
//
// state  | meaning
// IDLE   | waiting for a rising edge of db_level
// PRESS1 | first press in progress, timing toward a long press
// GAP    | first press released, waiting for a second press or timeout
// PRESS2 | second press of a double click, waiting for release
// LONG   | long press qualified, waiting for release
module btn_event_decoder #(
  parameter int unsigned LONG_TICKS = 50_000_000,
  parameter int unsigned GAP_TICKS  = 25_000_000,
  parameter int unsigned W          = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  input  logic en,
  output logic short_tick,
  output logic double_tick,
  output logic long_tick,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [W-1:0] LONG_LAST = W'(LONG_TICKS - 1);
  localparam logic [W-1:0] GAP_LAST  = W'(GAP_TICKS - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           prev_q;
  logic           short_q, short_d;
  logic           double_q, double_d;
  logic           long_q, long_d;
  logic           held_q, held_d;
  logic           rise;

  assign rise = db_level & ~prev_q;

  // State, counter, edge-detect history and registered outputs.
  // prev resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= db_level;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= held_d;
    end
  end

  // Next-state, counter and tick decisions; counter clears on every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    held_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESS1;
            cnt_d   = '0;
          end
        end
        PRESS1: begin
          // Release beats the long-press decision on the same edge.
          if (!db_level) begin
            state_d = GAP;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            cnt_d   = '0;
            long_d  = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          // A press on the expiry edge still counts as a double click.
          if (db_level) begin
            state_d  = PRESS2;
            cnt_d    = '0;
            double_d = 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            short_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESS2: begin
          if (!db_level) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        LONG: begin
          held_d = 1'b1;
          if (!db_level) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign short_tick  = short_q;
  assign double_tick = double_q;
  assign long_tick   = long_q;
  assign held        = held_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with a timestamp-based reference model.
module tb_btn_event_decoder;

  localparam int LT = 8;
  localparam int GT = 4;

  logic clk = 1'b0;
  logic reset, db_level, en;
  logic short_tick, double_tick, long_tick, held, busy;

  btn_event_decoder #(.LONG_TICKS(LT), .GAP_TICKS(GT), .W(4)) dut (
    .clk(clk), .reset(reset), .db_level(db_level), .en(en),
    .short_tick(short_tick), .double_tick(double_tick), .long_tick(long_tick),
    .held(held), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: phases with edge timestamps instead of a counter.
  // ph: 0 idle, 1 first press, 2 released, 3 second press, 4 long held
  int m_e = 0;
  int ph = 0;
  int t0 = 0;
  bit m_prev = 1'b1;
  bit es = 0, ed = 0, el = 0, eh = 0;

  always @(posedge clk) begin
    bit rise;
    m_e++;
    es = 0; ed = 0; el = 0;
    if (!reset) begin
      ph = 0; eh = 0; m_prev = 1'b1;
    end else begin
      rise = db_level && !m_prev;
      if (!en) begin
        ph = 0; eh = 0;
      end else begin
        case (ph)
          0: if (rise) begin ph = 1; t0 = m_e; end
          1: if (!db_level) begin ph = 2; t0 = m_e; end
             else if (m_e - t0 == LT) begin ph = 4; el = 1; eh = 1; end
          2: if (db_level) begin ph = 3; ed = 1; end
             else if (m_e - t0 == GT) begin ph = 0; es = 1; end
          3: if (!db_level) ph = 0;
          4: if (!db_level) begin ph = 0; eh = 0; end
          default: ph = 0;
        endcase
      end
      m_prev = db_level;
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int r, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at rel edge %0d: actual=%0d expected=%0d", name, r, act, exp);
    end
  endtask

  // Per-scenario stimulus: relative edge r -> input values sampled at that edge.
  function automatic bit stim_db(input int id, input int r);
    case (id)
      1: return (r >= 10 && r <= 14);
      2: return (r >= 10 && r <= 30);
      3: return (r >= 10 && r <= 12) || (r >= 15 && r <= 35);
      4: return (r >= 10 && r <= 12) || (r >= 17 && r <= 25);
      5: return (r >= 10 && r <= 40) || (r >= 46 && r <= 49);
      6: return (r >= 10 && r <= 14);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit stim_rst(input int id, input int r);
    if (r <= 2) return 1'b0;
    if (id == 5 && (r == 14 || r == 15)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit stim_en(input int id, input int r);
    return !(id == 6 && r == 17);
  endfunction

  int n_short, n_double, n_long, short_at, double_at, long_at;
  int held_first, held_last, busy_last, busy_win;

  task automatic run_scenario(input int id, input int n);
    n_short = 0; n_double = 0; n_long = 0;
    short_at = -1; double_at = -1; long_at = -1;
    held_first = -1; held_last = -1; busy_last = -1; busy_win = 0;
    for (int r = 1; r <= n; r++) begin
      db_level = stim_db(id, r);
      reset    = stim_rst(id, r);
      en       = stim_en(id, r);
      @(negedge clk);
      chk("short_tick",  r, int'(short_tick),  int'(es));
      chk("double_tick", r, int'(double_tick), int'(ed));
      chk("long_tick",   r, int'(long_tick),   int'(el));
      chk("held",        r, int'(held),        int'(eh));
      chk("busy",        r, int'(busy),        int'(ph != 0));
      if (int'(short_tick) + int'(double_tick) + int'(long_tick) > 1)
        chk("one_tick", r, int'(short_tick) + int'(double_tick) + int'(long_tick), 1);
      if (short_tick)  begin n_short++;  short_at  = r; end
      if (double_tick) begin n_double++; double_at = r; end
      if (long_tick)   begin n_long++;   long_at   = r; end
      if (held) begin if (held_first < 0) held_first = r; held_last = r; end
      if (busy) busy_last = r;
      if (id == 5 && r >= 14 && r <= 45 && (busy || held || short_tick || double_tick || long_tick))
        busy_win++;
    end
  endtask

  initial begin
    reset = 1'b0; db_level = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("reset_busy", 0, int'(busy), 0);
    chk("reset_held", 0, int'(held), 0);

    run_scenario(1, 30);
    chk("s1_short_at", 0, short_at, 19);
    chk("s1_n_short", 0, n_short, 1);
    chk("s1_n_other", 0, n_long + n_double, 0);
    chk("s1_busy_last", 0, busy_last, 18);

    run_scenario(2, 40);
    chk("s2_long_at", 0, long_at, 18);
    chk("s2_n_long", 0, n_long, 1);
    chk("s2_n_short", 0, n_short + n_double, 0);
    chk("s2_held_first", 0, held_first, 18);
    chk("s2_held_last", 0, held_last, 30);

    run_scenario(3, 45);
    chk("s3_double_at", 0, double_at, 15);
    chk("s3_n_double", 0, n_double, 1);
    chk("s3_n_other", 0, n_long + n_short, 0);
    chk("s3_busy_last", 0, busy_last, 35);

    run_scenario(4, 30);
    chk("s4_double_at", 0, double_at, 17);
    chk("s4_n_short", 0, n_short, 0);

    run_scenario(5, 60);
    chk("s5_quiet_window", 0, busy_win, 0);
    chk("s5_short_at", 0, short_at, 54);
    chk("s5_n_other", 0, n_long + n_double, 0);

    run_scenario(6, 30);
    chk("s6_n_short", 0, n_short, 0);
    chk("s6_busy_last", 0, busy_last, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
